// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memory-op encoding,
// FSM state encoding and small op-classification helpers.
package lsu_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return |addr_lo;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for 32-bit data: load extract/extend and store
// strobe generation with data replication. Kept standalone for reuse.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  logic [15:0] lane;

  always_comb begin
    lane      = 16'(rdata >> {addr_lo, 3'b000});
    load_data = rdata;
    wstrb     = 4'b0000;
    wdata     = store_data;
    case (op)
      OP_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU: load_data = {24'd0, lane[7:0]};
      OP_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
      OP_LHU: load_data = {16'd0, lane[15:0]};
      OP_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      OP_SW:  wstrb = 4'hF;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Multi-cycle MEM pipeline stage: holds one instruction, issues at most one
// SRAM request via addr_ok/data_ok, formats load results, and drains on flush.
//
// state | meaning
// IDLE  | no instruction held
// REQ   | request on the bus, waiting for addr_ok (never withdrawn)
// WAIT  | request accepted, waiting for data_ok
// DONE  | result ready, offered to WB
// DRAIN | instruction flushed, swallowing the one response still in flight
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [3:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_rkd_value,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic              flush,
  output logic              mem_to_wb_valid,
  input  logic              wb_allowin,
  output logic [ADDR_W-1:0] mem_pc,
  output logic              mem_rf_we,
  output logic [RF_AW-1:0]  mem_rf_waddr,
  output logic [DATA_W-1:0] mem_rf_wdata,
  output logic              mem_ale,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  lsu_state_e        state_q, state_d, entry_state;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rkd_q, rkd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        op_q, op_d;
  logic              rf_we_q, rf_we_d;
  logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic              ale_q, ale_d;

  logic              accept;
  logic              ex_misaligned;
  logic [ADDR_W-1:0] addr_full;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_wdata;
  logic [3:0]        store_wstrb;

  lsu_align u_align (
    .op         (op_q),
    .addr_lo    (alu_q[1:0]),
    .store_data (rkd_q),
    .rdata      (data_rdata),
    .load_data  (load_data),
    .wstrb      (store_wstrb),
    .wdata      (store_wdata)
  );

  assign addr_full     = ADDR_W'(alu_q);
  assign ex_misaligned = op_misaligned(ex_mem_op, ex_alu_result[1:0]);
  assign entry_state   = (op_is_mem(ex_mem_op) && !ex_misaligned) ? ST_REQ : ST_DONE;

  // A flush in the same cycle blocks acceptance so EX never sees a phantom handoff.
  assign mem_allowin = ((~mem_valid_q & ~(state_q inside {ST_REQ, ST_WAIT, ST_DRAIN}))
                       | ((state_q == ST_DONE) & wb_allowin)) & ~flush;
  assign accept      = ex_to_mem_valid & mem_allowin;

  assign data_req        = (state_q == ST_REQ);
  assign data_wr         = data_req & op_is_store(op_q);
  assign data_wstrb      = store_wstrb;
  assign data_wdata      = store_wdata;
  assign data_addr       = {addr_full[ADDR_W-1:2], 2'b00};
  assign mem_to_wb_valid = (state_q == ST_DONE) & mem_valid_q;

  assign mem_pc       = pc_q;
  assign mem_rf_we    = rf_we_q & ~ale_q;
  assign mem_rf_waddr = rf_waddr_q;
  assign mem_rf_wdata = result_q;
  assign mem_ale      = ale_q;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    rkd_d       = rkd_q;
    op_d        = op_q;
    rf_we_d     = rf_we_q;
    rf_waddr_d  = rf_waddr_q;
    ale_d       = ale_q;
    result_d    = result_q;

    case (state_q)
      ST_IDLE: if (accept) state_d = entry_state;
      // mem_valid_q low in REQ means a flush arrived while waiting for addr_ok.
      ST_REQ: if (data_addr_ok) state_d = (flush | ~mem_valid_q) ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (flush) begin
          state_d = data_data_ok ? ST_IDLE : ST_DRAIN;
        end else if (data_data_ok) begin
          state_d = ST_DONE;
          if (op_is_load(op_q)) result_d = load_data;
        end
      end
      ST_DRAIN: if (data_data_ok) state_d = ST_IDLE;
      ST_DONE: begin
        if (flush)           state_d = ST_IDLE;
        else if (wb_allowin) state_d = accept ? entry_state : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      mem_valid_d = 1'b1;
      pc_d        = ex_pc;
      alu_d       = ex_alu_result;
      rkd_d       = ex_rkd_value;
      op_d        = ex_mem_op;
      rf_we_d     = ex_rf_we;
      rf_waddr_d  = ex_rf_waddr;
      ale_d       = ex_misaligned;
      result_d    = ex_alu_result;
    end else if (flush | (mem_to_wb_valid & wb_allowin)) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      pc_q        <= '0;
      alu_q       <= '0;
      rkd_q       <= '0;
      op_q        <= OP_NONE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      ale_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      rkd_q       <= rkd_d;
      op_q        <= op_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      ale_q       <= ale_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory pipeline stage between EX and WB for the LoongArch-style five-stage core. It extends the fixed single-cycle MEM register to a multi-cycle stage with:
- byte, halfword and word loads and stores, with sign or zero extension;
- a request/response handshake to the data SRAM bridge (addr_ok/data_ok);
- misaligned-access detection;
- pipeline flush, including draining of responses already in flight.

## Interface
Parameters:
- ADDR_W, 32, address and PC width
- RF_AW, 5, register-file address width
- DATA_W, 32, data width; must be 32 (halfword/byte lanes derived from it)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- ex_to_mem_valid  in  1  EX holds a valid instruction
- mem_allowin  out  1  MEM accepts from EX this cycle
- ex_pc  in  ADDR_W  instruction PC
- ex_alu_result  in  DATA_W  effective address, or ALU result for non-memory ops
- ex_mem_op  in  4  encoding: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
- ex_rkd_value  in  DATA_W  store data
- ex_rf_we, ex_rf_waddr  in  1, RF_AW  destination register
- flush  in  1  kill the instruction held in MEM
- mem_to_wb_valid  out  1  result valid to WB
- wb_allowin  in  1  WB accepts
- mem_pc  out  ADDR_W  PC of the held instruction
- mem_rf_we, mem_rf_waddr, mem_rf_wdata  out  1, RF_AW, DATA_W  writeback bundle
- mem_ale  out  1  misaligned-address exception for the held instruction
- data_req, data_wr  out  1 each  request valid, write
- data_wstrb  out  4  byte strobes
- data_addr, data_wdata  out  ADDR_W, DATA_W  request address and write data
- data_addr_ok, data_data_ok  in  1 each  request accepted, response returned
- data_rdata  in  DATA_W  load data

## Operation
- **Capture:** on `ex_to_mem_valid & mem_allowin`, latch PC, ALU result, op, store data and rf fields; `mem_valid` ← 1. Otherwise, when `mem_to_wb_valid & wb_allowin`, `mem_valid` ← 0.
- **States:** IDLE, REQ, WAIT, DONE, DRAIN.
- **Entry state:**
  - Memory op, aligned: enter REQ.
  - Non-memory op: enter DONE.
  - Misaligned op (halfword with addr[0]=1, word with addr[1:0]≠0): enter DONE with `mem_ale`=1, `mem_rf_we`=0, and no request issued.
- **REQ:** `data_req`=1 with address, strobes and data held stable until `data_addr_ok`; then go to WAIT.
- **WAIT:** on `data_data_ok`, go to DONE.
  - Loads capture the formatted rdata into `mem_rf_wdata`.
  - Stores ignore rdata.
- **DONE:** `mem_to_wb_valid`=1. Advance to IDLE (or to the new entry state if EX refills in the same cycle) when `wb_allowin`.
- **Load formatting:** select lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- **Store formatting:**
  - SB: strobe `4'b0001<<addr[1:0]`, data = byte replicated ×4.
  - SH: strobe `4'b0011<<addr[1:0]`, data = half replicated ×2.
  - SW: strobe `4'hF`.
- **Aligned request address:** `data_addr` = {addr[ADDR_W-1:2], 2'b00}.
- **Flush:**
  - In IDLE or DONE: `mem_valid` ← 0 next edge.
  - In REQ: `data_req` stays asserted until `addr_ok` (the handshake may not be withdrawn), then go to DRAIN.
  - In WAIT: go to DRAIN.
  - DRAIN: discard the next `data_ok`, then go to IDLE. `mem_valid`=0 throughout; no writeback.
- **mem_allowin:** `~mem_valid & state∉{REQ,WAIT,DRAIN}` | (state==DONE & `wb_allowin`).

## Timing
- **Reset values:**
  - state = IDLE, `mem_valid`=0.
  - All outputs 0: `data_req`, `mem_to_wb_valid`, `mem_ale`, `mem_rf_we`, `data_wstrb`, `mem_pc`, `mem_rf_wdata`.
- **Reset mid-transaction:** returns to IDLE immediately; the bridge is reset by the same `resetn`.
- **Latency:**
  - Non-memory op: 1 cycle in MEM.
  - Memory op with zero-wait slave: 3 cycles (REQ, WAIT, DONE); `data_ok` arrives no earlier than the cycle after `addr_ok`.
- **Throughput:** at most one outstanding request.
- **Outputs:** `data_req` and `mem_to_wb_valid` are decoded from registered state only; no combinational path from `data_addr_ok`.
- **Simultaneous flush and data_ok in WAIT:** response is discarded, next state IDLE.
- **Simultaneous flush and ex_to_mem_valid:** EX is not accepted that cycle.

## Structure
- Shared package `lsu_pkg`: the mem_op encoding constants and the state encoding.
- One sub-module `lsu_align`: combinational load extract/extend and store strobe/replicate. It is shared with a future uncached path.

## Test plan
- ALU op (result 0x1234) with wb_allowin=1 → mem_to_wb_valid in cycle 1, mem_rf_wdata=0x1234, data_req never asserted.
- LB at addr 0x1003, rdata 0x80FFFFFF, addr_ok +0 cycles, data_ok +1 cycle → data_addr 0x1000, wdata 0xFFFFFF80 written back in cycle 3. LBU on the same stimulus → 0x00000080.
- SH at 0x2002, rkd 0xABCD5678 → wstrb 4'b1100, wdata 0x56785678, data_wr=1. addr_ok withheld 3 cycles → req and payload stable throughout.
- LW at 0x3001 → mem_ale=1, mem_rf_we=0, no data_req, passes to WB after 1 cycle.
- Flush in WAIT with data_ok 4 cycles later → mem_allowin=0 until data_ok, no mem_to_wb_valid, next load issues correctly afterwards.
- wb_allowin=0 for 5 cycles in DONE → mem_rf_wdata and mem_pc held, mem_allowin=0. Assert resetn=0 mid-REQ → data_req=0 immediately.
